mdu_ctrl: RTL

//  Sequencer and owner of HI/LO for the E-stage multiply/divide path. Accepts MDU ops

---
 rtl/mdu_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencer and HI/LO owner for the E-stage multiply/divide path.
// Issues MULT/MULTU/DIV/DIVU, models their latency with a down-counter FSM,
// applies MTLO/MTHI immediately, and suppresses every E-stage side effect on
// an exception flush request.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_isMDU,
  input  logic [3:0]  E_MDUOP,
  input  logic [31:0] E_rsOut,
  input  logic [31:0] E_rtOut,
  input  logic        Req,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] MDUOut
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_LAT + 1) > 4) ? $clog2(MAX_LAT + 1) : 4;
  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           r_state, w_nextState;
  logic [CNT_W-1:0] r_cnt, w_nextCnt;
  logic             r_busy, w_nextBusy;
  logic             w_commit;

  logic [31:0] r_hi, r_lo;
  logic [31:0] r_pendHi, r_pendLo;
  logic        r_pendWr;

  logic        w_idle, w_opLive, w_mtLo, w_mtHi;
  logic        w_isDiv, w_isUnsigned;
  logic [63:0] w_mulA, w_mulB, w_mulProd;
  logic        w_rsNeg, w_rtNeg, w_divByZero;
  logic [31:0] w_absRs, w_absRt, w_divisor, w_uq, w_ur, w_quot, w_rem;

  // Issue qualification: any MDU op only acts when IDLE and not flushed
  always_comb begin
    w_idle       = (r_state == S_IDLE);
    w_opLive     = E_isMDU & ~Req & w_idle;
    Start        = w_opLive & (E_MDUOP[3:2] == 2'b00);
    w_mtLo       = w_opLive & (E_MDUOP == 4'd6);
    w_mtHi       = w_opLive & (E_MDUOP == 4'd7);
    w_isDiv      = E_MDUOP[1];
    w_isUnsigned = E_MDUOP[0];
  end

  // Multiply datapath: sign-extend for MULT, zero-extend for MULTU, keep low 64 bits
  always_comb begin
    w_mulA    = {{32{E_rsOut[31] & ~w_isUnsigned}}, E_rsOut};
    w_mulB    = {{32{E_rtOut[31] & ~w_isUnsigned}}, E_rtOut};
    w_mulProd = w_mulA * w_mulB;
  end

  // Divide datapath: divide magnitudes, then restore signs (quotient toward zero,
  // remainder takes the dividend sign); a zero divisor is replaced to keep results defined
  always_comb begin
    w_rsNeg     = ~w_isUnsigned & E_rsOut[31];
    w_rtNeg     = ~w_isUnsigned & E_rtOut[31];
    w_absRs     = w_rsNeg ? (~E_rsOut + 32'd1) : E_rsOut;
    w_absRt     = w_rtNeg ? (~E_rtOut + 32'd1) : E_rtOut;
    w_divByZero = (E_rtOut == 32'd0);
    w_divisor   = w_divByZero ? 32'd1 : w_absRt;
    w_uq        = w_absRs / w_divisor;
    w_ur        = w_absRs % w_divisor;
    w_quot      = (w_rsNeg ^ w_rtNeg) ? (~w_uq + 32'd1) : w_uq;
    w_rem       = w_rsNeg ? (~w_ur + 32'd1) : w_ur;
  end

  // Next-state logic: load the latency on issue, count down, commit on the last cycle
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextBusy  = r_busy;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_nextState = w_isDiv ? S_DIV : S_MUL;
          w_nextCnt   = w_isDiv ? DIV_LAT : MULT_LAT;
          w_nextBusy  = 1'b1;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == CNT_ONE) begin
          w_commit    = 1'b1;
          w_nextState = S_IDLE;
          w_nextCnt   = '0;
          w_nextBusy  = 1'b0;
        end else begin
          w_nextCnt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextCnt   = '0;
        w_nextBusy  = 1'b0;
      end
    endcase
  end

  // State, counter and busy registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_busy  <= w_nextBusy;
    end
  end

  // Capture the result at issue; a divide by zero leaves HI/LO untouched at commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pendHi <= '0;
      r_pendLo <= '0;
      r_pendWr <= 1'b0;
    end else if (Start) begin
      if (w_isDiv) begin
        r_pendHi <= w_rem;
        r_pendLo <= w_quot;
        r_pendWr <= ~w_divByZero;
      end else begin
        r_pendHi <= w_mulProd[63:32];
        r_pendLo <= w_mulProd[31:0];
        r_pendWr <= 1'b1;
      end
    end
  end

  // Architectural HI/LO: committed results or immediate MTHI/MTLO writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (r_pendWr) begin
        r_hi <= r_pendHi;
        r_lo <= r_pendLo;
      end
    end else begin
      if (w_mtLo) r_lo <= E_rsOut;
      if (w_mtHi) r_hi <= E_rsOut;
    end
  end

  // Outputs: MFHI selects HI, every other op code reads LO
  always_comb begin
    Busy   = r_busy;
    MDUOut = (E_MDUOP == 4'd5) ? r_hi : r_lo;
  end

endmodule
